// File: rtl/crack_pair_ctrl.sv
// Dual ARC4 crack-engine controller: shared launch, round-robin ct_mem arbiter, first-valid-key collection.
// Optional arbitration conflict counter enabled by `define CRACK_PAIR_STALL_CNT_EN.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | rdy=1, waiting for en; last result held on key/key_valid
// S_LAUNCH   | waiting for both engines idle, then pulse en0/en1
// S_WAITBUSY | waiting for both engines to drop rdy
// S_RUN      | engines searching; first finisher with a valid key wins
// S_DRAIN    | result fixed; waiting for the other engine to go idle

module crack_pair_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter int KEY_W  = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic              rdy,
   output logic [KEY_W-1:0]  key,
   output logic              key_valid,
   output logic              en0,
   output logic              en1,
   input  logic              rdy0,
   input  logic              rdy1,
   input  logic [KEY_W-1:0]  key0,
   input  logic [KEY_W-1:0]  key1,
   input  logic              kv0,
   input  logic              kv1,
   input  logic              req0,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              vld0,
   output logic              vld1,
   output logic [DATA_W-1:0] ct_rddata,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_q,
   output logic [15:0]       stall_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAITBUSY,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [KEY_W-1:0]   key_nxt;
   logic               key_valid_nxt;
   logic               en_pulse;
   logic               en_pulse_nxt;
   logic               done0;
   logic               done1;
   logic               done0_nxt;
   logic               done1_nxt;
   logic               fin0;
   logic               fin1;
   logic               start_run;

   logic               last;
   logic [ADDR_W-1:0]  mem_addr_q;

   // An engine finishes on the first RUN cycle in which its rdy is seen high.
   assign fin0      = rdy0 & ~done0;
   assign fin1      = rdy1 & ~done1;
   assign start_run = (state == S_IDLE) & en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         key       <= '0;
         key_valid <= 1'b0;
         en_pulse  <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
      end else begin
         state     <= state_nxt;
         key       <= key_nxt;
         key_valid <= key_valid_nxt;
         en_pulse  <= en_pulse_nxt;
         done0     <= done0_nxt;
         done1     <= done1_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      key_nxt       = key;
      key_valid_nxt = key_valid;
      en_pulse_nxt  = 1'b0;
      done0_nxt     = done0;
      done1_nxt     = done1;
      case (state)
         S_IDLE: begin
            if (en) begin
               key_nxt       = '0;
               key_valid_nxt = 1'b0;
               state_nxt     = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            if (rdy0 && rdy1) begin
               en_pulse_nxt = 1'b1;
               state_nxt    = S_WAITBUSY;
            end
         end
         S_WAITBUSY: begin
            done0_nxt = 1'b0;
            done1_nxt = 1'b0;
            if (!rdy0 && !rdy1) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            done0_nxt = done0 | fin0;
            done1_nxt = done1 | fin1;
            // Engine 0 is checked first so it wins a same-cycle tie.
            if (fin0 && kv0) begin
               key_nxt       = key0;
               key_valid_nxt = 1'b1;
               state_nxt     = S_DRAIN;
            end else if (fin1 && kv1) begin
               key_nxt       = key1;
               key_valid_nxt = 1'b1;
               state_nxt     = S_DRAIN;
            end else if ((done0 || fin0) && (done1 || fin1)) begin
               key_valid_nxt = 1'b0;
               state_nxt     = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (rdy0 && rdy1) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   assign rdy = (state == S_IDLE);
   assign en0 = en_pulse;
   assign en1 = en_pulse;

   // Round-robin: last=1 means engine 1 was granted most recently, so engine 0 wins a tie.
   assign gnt0 = ~rst & req0 & (~req1 | last);
   assign gnt1 = ~rst & req1 & (~req0 | ~last);

   always_comb begin
      mem_addr = mem_addr_q;
      if (gnt0) begin
         mem_addr = addr0;
      end else if (gnt1) begin
         mem_addr = addr1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last       <= 1'b1;
         mem_addr_q <= '0;
         vld0       <= 1'b0;
         vld1       <= 1'b0;
      end else begin
         mem_addr_q <= mem_addr;
         vld0       <= gnt0;
         vld1       <= gnt1;
         if (gnt0) begin
            last <= 1'b0;
         end else if (gnt1) begin
            last <= 1'b1;
         end
      end
   end

   assign ct_rddata = mem_q;

`ifdef CRACK_PAIR_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if (start_run) begin
         stall_q <= '0;
      end else if (req0 && req1 && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cnt = stall_q;
`else
   assign stall_cnt = 16'd0;
`endif

endmodule
